// File: rtl/fetch_tlb_array_pkg.sv
// Shared constants for the fetch TLB: entry field layout and replacement pointer sizing.
// Entry layout (LSB first): valid, present, rw, pfn, vpn.
package fetch_tlb_array_pkg;

    localparam int NUM_ENTRIES_DEF = 8;
    localparam int VPN_W_DEF       = 20;
    localparam int PFN_W_DEF       = 3;
    localparam int LIMIT_W_DEF     = 20;
    localparam int PERF_W          = 32;

    localparam int ENT_VALID_OFS   = 0;
    localparam int ENT_PRESENT_OFS = 1;
    localparam int ENT_RW_OFS      = 2;
    localparam int ENT_PFN_OFS     = 3;

    // Replacement pointer width for the default table size.
    localparam int TLB_PTR_W = $clog2(NUM_ENTRIES_DEF);

    function automatic int tlb_ptr_w(input int num_entries);
        return (num_entries < 2) ? 1 : $clog2(num_entries);
    endfunction

    function automatic int ent_vpn_ofs(input int pfn_w);
        return ENT_PFN_OFS + pfn_w;
    endfunction

    function automatic int ent_w(input int vpn_w, input int pfn_w);
        return ENT_PFN_OFS + pfn_w + vpn_w;
    endfunction

endpackage

// File: rtl/fetch_tlb_array_if.sv
// Lookup, response and fill/flush bundle for the fetch TLB.
// master drives requests and fills; slave is the TLB.
interface fetch_tlb_array_if #(
    parameter int VPN_W   = 20,
    parameter int PFN_W   = 3,
    parameter int LIMIT_W = 20
);
    logic                 lk_valid;
    logic [VPN_W+11:0]    lk_addr;
    logic                 lk_write;
    logic [LIMIT_W-1:0]   seg_limit;

    logic                 rsp_valid;
    logic [PFN_W-1:0]     rsp_pfn;
    logic                 rsp_hit;
    logic                 rsp_page_fault;
    logic                 rsp_prot_exp;

    logic                 fill_valid;
    logic                 fill_ready;
    logic [VPN_W-1:0]     fill_vpn;
    logic [PFN_W-1:0]     fill_pfn;
    logic                 fill_present;
    logic                 fill_rw;
    logic                 flush;

    modport master (
        output lk_valid, lk_addr, lk_write, seg_limit,
        output fill_valid, fill_vpn, fill_pfn, fill_present, fill_rw, flush,
        input  rsp_valid, rsp_pfn, rsp_hit, rsp_page_fault, rsp_prot_exp, fill_ready
    );

    modport slave (
        input  lk_valid, lk_addr, lk_write, seg_limit,
        input  fill_valid, fill_vpn, fill_pfn, fill_present, fill_rw, flush,
        output rsp_valid, rsp_pfn, rsp_hit, rsp_page_fault, rsp_prot_exp, fill_ready
    );
endinterface

// File: rtl/fetch_tlb_array_match.sv
// Per-entry comparator: lookup hit (valid, present, vpn match) and fill-target match (valid, vpn match).
// Purely combinational, no backpressure.
module tlb_entry_match #(
    parameter int VPN_W = 20
) (
    input  logic             valid,
    input  logic             present,
    input  logic [VPN_W-1:0] ent_vpn,
    input  logic [VPN_W-1:0] lk_vpn,
    input  logic [VPN_W-1:0] fill_vpn,
    output logic             lk_hit,
    output logic             fill_hit
);
    assign lk_hit   = valid & present & (ent_vpn == lk_vpn);
    assign fill_hit = valid & (ent_vpn == fill_vpn);
endmodule

// File: rtl/fetch_tlb_array.sv
// Fully associative fetch TLB with segment-limit/write checks and round-robin replacement.
// Latency: response 1 cycle after lk_valid, full rate. Backpressure: fill_ready drops only while flush=1.
// FETCH_TLB_PERF_EN adds saturating 32-bit hit/miss counters (perf_hits, perf_misses).
module fetch_tlb_array
    import fetch_tlb_array_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int VPN_W       = VPN_W_DEF,
    parameter int PFN_W       = PFN_W_DEF,
    parameter int LIMIT_W     = LIMIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_tlb_array_if.slave  bus
`ifdef FETCH_TLB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_hits,
    output logic [PERF_W-1:0] perf_misses
`endif
);
    localparam int AW      = VPN_W + 12;
    localparam int PTR_W   = tlb_ptr_w(NUM_ENTRIES);
    localparam int VPN_OFS = ent_vpn_ofs(PFN_W);
    localparam int ENT_W   = ent_w(VPN_W, PFN_W);
    localparam logic [AW-1:0] LINE_MASK = ~AW'(31);

    logic [ENT_W-1:0]       ent_q [NUM_ENTRIES];
    logic [PTR_W-1:0]       ptr_q;

    logic [NUM_ENTRIES-1:0] lk_hit_vec;
    logic [NUM_ENTRIES-1:0] fill_hit_vec;
    logic [VPN_W-1:0]       lk_vpn;

    logic                   lk_any;
    logic [PTR_W-1:0]       lk_idx;
    logic                   fill_match_any;
    logic [PTR_W-1:0]       fill_match_idx;
    logic                   inv_any;
    logic [PTR_W-1:0]       inv_idx;
    logic [PTR_W-1:0]       fill_idx;
    logic                   fill_advance;
    logic                   fill_fire;
    logic [ENT_W-1:0]       fill_ent;

    logic [PFN_W-1:0]       hit_pfn;
    logic                   hit_rw;
    logic                   seg_viol;
    logic                   prot_nxt;

    logic                   rsp_valid_q;
    logic                   rsp_hit_q;
    logic [PFN_W-1:0]       rsp_pfn_q;
    logic                   rsp_prot_q;

    assign lk_vpn = bus.lk_addr[AW-1:12];

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_match
        tlb_entry_match #(.VPN_W(VPN_W)) u_match (
            .valid    (ent_q[g][ENT_VALID_OFS]),
            .present  (ent_q[g][ENT_PRESENT_OFS]),
            .ent_vpn  (ent_q[g][VPN_OFS +: VPN_W]),
            .lk_vpn   (lk_vpn),
            .fill_vpn (bus.fill_vpn),
            .lk_hit   (lk_hit_vec[g]),
            .fill_hit (fill_hit_vec[g])
        );
    end

    // Descending scans so the lowest index wins each priority select.
    always_comb begin
        lk_any         = 1'b0;
        lk_idx         = '0;
        fill_match_any = 1'b0;
        fill_match_idx = '0;
        inv_any        = 1'b0;
        inv_idx        = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (lk_hit_vec[i]) begin
                lk_any = 1'b1;
                lk_idx = PTR_W'(i);
            end
            if (fill_hit_vec[i]) begin
                fill_match_any = 1'b1;
                fill_match_idx = PTR_W'(i);
            end
            if (!ent_q[i][ENT_VALID_OFS]) begin
                inv_any = 1'b1;
                inv_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        fill_idx     = ptr_q;
        fill_advance = 1'b0;
        if (fill_match_any) begin
            fill_idx = fill_match_idx;
        end else if (inv_any) begin
            fill_idx = inv_idx;
        end else begin
            fill_advance = 1'b1;
        end
    end

    always_comb begin
        fill_ent                     = '0;
        fill_ent[ENT_VALID_OFS]      = 1'b1;
        fill_ent[ENT_PRESENT_OFS]    = bus.fill_present;
        fill_ent[ENT_RW_OFS]         = bus.fill_rw;
        fill_ent[ENT_PFN_OFS +: PFN_W] = bus.fill_pfn;
        fill_ent[VPN_OFS +: VPN_W]   = bus.fill_vpn;
    end

    assign bus.fill_ready = ~bus.flush;
    assign fill_fire      = bus.fill_valid & bus.fill_ready;

    assign hit_pfn  = lk_any ? ent_q[lk_idx][ENT_PFN_OFS +: PFN_W] : '0;
    assign hit_rw   = ent_q[lk_idx][ENT_RW_OFS];
    assign seg_viol = (bus.lk_addr & LINE_MASK) > AW'(bus.seg_limit);
    assign prot_nxt = seg_viol | (bus.lk_write & lk_any & ~hit_rw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            ptr_q <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i][ENT_VALID_OFS] <= 1'b0;
            end
            ptr_q <= '0;
        end else if (fill_fire) begin
            ent_q[fill_idx] <= fill_ent;
            if (fill_advance) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    // Results are computed from the pre-update table, so same-cycle fills/flushes are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_pfn_q   <= '0;
            rsp_prot_q  <= 1'b0;
        end else begin
            rsp_valid_q <= bus.lk_valid;
            rsp_hit_q   <= bus.lk_valid & lk_any;
            rsp_pfn_q   <= bus.lk_valid ? hit_pfn : '0;
            rsp_prot_q  <= bus.lk_valid & prot_nxt;
        end
    end

    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_hit        = rsp_hit_q;
    assign bus.rsp_pfn        = rsp_pfn_q;
    assign bus.rsp_prot_exp   = rsp_prot_q;
    assign bus.rsp_page_fault = rsp_valid_q & ~rsp_hit_q;

`ifdef FETCH_TLB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (rsp_valid_q) begin
            if (rsp_hit_q && perf_hits != '1) begin
                perf_hits <= perf_hits + 1'b1;
            end
            if (!rsp_hit_q && perf_misses != '1) begin
                perf_misses <= perf_misses + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_tlb_array.md
FETCH_TLB_ARRAY -- requirements
Module: fetch_tlb_array

Interface
REQ-001 Parameter NUM_ENTRIES, default 8: TLB entry count; power of two, 2..64.
REQ-002 Parameter VPN_W, default 20: virtual page number width; address width is VPN_W+12.
REQ-003 Parameter PFN_W, default 3: physical frame number width.
REQ-004 Parameter LIMIT_W, default 20: segment limit width.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 lk_valid  input  1  lookup request strobe.
REQ-008 lk_addr  input  VPN_W+12  lookup virtual address.
REQ-009 lk_write  input  1  lookup is a write access.
REQ-010 seg_limit  input  LIMIT_W  segment limit, zero-extended for compare.
REQ-011 rsp_valid  output  1  lookup result valid.
REQ-012 rsp_pfn  output  PFN_W  translated frame number.
REQ-013 rsp_hit  output  1  matching valid and present entry found.
REQ-014 rsp_page_fault  output  1  no matching valid and present entry.
REQ-015 rsp_prot_exp  output  1  segment-limit or write-permission violation.
REQ-016 fill_valid / fill_ready  input / output  1 / 1  fill handshake.
REQ-017 fill_vpn, fill_pfn, fill_present, fill_rw  input  VPN_W, PFN_W, 1, 1  fill entry contents.
REQ-018 flush  input  1  invalidate all entries.

Function
REQ-019 Each entry SHALL hold valid, present, rw, vpn and pfn registers.
REQ-020 The block SHALL register a lookup when lk_valid=1 and return the result with rsp_valid=1 exactly one cycle later; rsp_valid SHALL be 0 otherwise. Back-to-back lookups SHALL be supported at full rate.
REQ-021 An entry SHALL hit when valid=1, present=1 and vpn equals lk_addr[VPN_W+11:12].
REQ-022 On multiple hits, rsp_pfn SHALL come from the lowest-index hit. On no hit, rsp_pfn SHALL be 0.
REQ-023 rsp_page_fault SHALL equal rsp_valid & ~rsp_hit.
REQ-024 rsp_prot_exp SHALL be asserted with rsp_valid when either condition holds:
- {lk_addr[VPN_W+11:5], 5'b0} > zero-extended seg_limit, or
- lk_write=1 and the hit entry has rw=0.
REQ-025 A lookup SHALL use the table contents from before any fill or flush in the same cycle.
REQ-026 fill_ready SHALL be 1 except during the cycle flush=1. A fill completes when fill_valid & fill_ready.
REQ-027 Fill targeting:
- If a valid entry with fill_vpn exists, the fill SHALL overwrite the lowest-index such entry in place; the replacement pointer does not move.
- Otherwise it SHALL write the first invalid entry, lowest index first.
- If no entry is invalid, it SHALL write the entry at the round-robin pointer and advance the pointer, wrapping NUM_ENTRIES-1 to 0.
REQ-028 A filled entry SHALL be written with valid=1.
REQ-029 flush SHALL clear every valid bit and reset the pointer to 0 on the next edge. Flush SHALL take priority over a simultaneous fill, which is dropped. Flush SHALL NOT cancel an in-flight response.

Reset
REQ-030 While rst_n=0:
- all valid bits = 0, pointer = 0;
- rsp_valid, rsp_hit, rsp_page_fault, rsp_prot_exp = 0 and rsp_pfn = 0;
- fill_ready = 1 once rst_n is released.
REQ-031 A reset assertion mid-lookup SHALL discard the pending response.

Configuration
REQ-032 Macro FETCH_TLB_PERF_EN enables performance counters.
- Defined: add outputs perf_hits and perf_misses, 32 bits each. They count responses with rsp_hit=1 and responses with rsp_page_fault=1 respectively, saturate at all-ones, clear on reset and do not clear on flush.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-033 A shared package SHALL hold:
- the entry field widths and offsets;
- the localparam for the replacement pointer width, $clog2(NUM_ENTRIES).
REQ-034 Sub-module tlb_entry_match SHALL perform the per-entry compare and be instantiated NUM_ENTRIES times. Priority select and replacement logic SHALL stay in the top module.

Verification
REQ-035 Reset, then look up 0x0000_5000 -> one cycle later rsp_valid=1, rsp_page_fault=1, rsp_pfn=0.
REQ-036 Fill vpn=0x00005, pfn=3, present=1, rw=1, then look up 0x0000_5ABC -> rsp_hit=1, rsp_pfn=3, no exceptions.
REQ-037 Fill 9 distinct VPNs into an 8-entry TLB -> the 9th replaces entry 0; look up the first VPN -> page fault, and pointer = 1.
REQ-038 seg_limit=0x00FFF, look up 0x0000_1000 with a hit -> rsp_prot_exp=1; a write to a hit entry with rw=0 -> rsp_prot_exp=1.
REQ-039 Assert flush and fill_valid together -> fill dropped, then all lookups page fault. A lookup issued in the same cycle returns the pre-flush hit.
REQ-040 Refill an existing vpn with pfn=5 -> no new entry is consumed, and a lookup returns pfn=5.
